// File: rtl/div_uns_seq.sv
// ---------------------------------------------------------------------------
// div_uns_seq
//
// Purpose:
//   Sequential unsigned restoring radix-2 divider. It takes one operand pair
//   through a valid/ready handshake and retires one quotient bit per clock,
//   MSB first. It presents Q = floor(X/Y) and R = X mod Y through a second
//   valid/ready handshake, and holds the result until the consumer takes it.
//
//   Divide by zero gives Q = all ones, R = X[widthY-1:0] and dz_o = 1.
//   - Default build: a zero divisor runs the normal iteration. Comparing
//     against zero always succeeds, so every quotient bit becomes 1, and the
//     partial remainder ends up holding the low dividend bits.
//   - Optional feature, macro DIVUNS_FAST_DZ_EN: a zero divisor skips the
//     iteration. The divider loads the divide-by-zero result directly and
//     presents it one cycle after acceptance.
//
// Parameters:
//   widthX  dividend / quotient width
//   widthY  divisor / remainder width (1 <= widthY <= widthX)
//
// Ports:
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       synchronous active-high reset
//   X            in   widthX  dividend
//   Y            in   widthY  divisor
//   in_valid_i   in   1       X/Y valid
//   in_ready_o   out  1       divider idle and able to accept a pair
//   Q            out  widthX  quotient
//   R            out  widthY  remainder
//   dz_o         out  1       divide-by-zero flag of the presented result
//   out_valid_o  out  1       Q/R/dz_o valid
//   out_ready_i  in   1       consumer accepts the result
// ---------------------------------------------------------------------------
module div_uns_seq #(
  parameter int widthX = 16,
  parameter int widthY = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [widthX-1:0] X,
  input  logic [widthY-1:0] Y,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [widthX-1:0] Q,
  output logic [widthY-1:0] R,
  output logic              dz_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  localparam int CntW = $clog2(widthX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [widthX-1:0] dividend_q, dividend_d;
  logic [widthY-1:0] divisor_q, divisor_d;
  logic [widthX-1:0] quot_q, quot_d;
  logic [widthY:0]   partRem_q, partRem_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              dz_q, dz_d;

  logic [widthY+1:0] shifted;
  logic [widthY+1:0] yExt;
  logic              fitBit;
  logic              accept;
  logic              lastIter;

  // One restoring step. The next dividend bit is shifted into the partial
  // remainder, and the result is compared against the divisor.
  // The compare uses an extra top bit, so the full stored remainder always
  // takes part. For a non-zero divisor, the stored remainder is always below
  // the divisor, so this extra bit stays zero. For a zero divisor, the
  // compare always succeeds. The truncated difference then simply keeps the
  // low dividend bits that were shifted in, which is the value required for
  // R in that case.
  always_comb begin
    shifted = {partRem_q, dividend_q[widthX-1]};
    yExt    = {2'b00, divisor_q};
    fitBit  = (shifted >= yExt);
  end

  // Control FSM, next-state and handshake outputs.
  // in_ready_o is high only in IDLE, and out_valid_o only in DONE.
  // BUSY lasts exactly widthX cycles. The edge that retires the last
  // quotient bit moves the FSM to DONE. With the fast divide-by-zero
  // option, a zero divisor goes straight from IDLE to DONE.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    accept      = 1'b0;
    lastIter    = (count_q == CntW'(1));
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          accept = 1'b1;
`ifdef DIVUNS_FAST_DZ_EN
          state_d = (Y == '0) ? DONE : BUSY;
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        if (lastIter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next-state.
  // - Acceptance: the divider captures the operands, clears the quotient and
  //   the partial remainder, and loads the iteration counter.
  // - Each BUSY cycle: the divider consumes one dividend bit and appends one
  //   quotient bit.
  // - Otherwise: every register holds. This keeps the result stable in DONE
  //   and makes the divider ignore the inputs outside IDLE.
  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    partRem_d  = partRem_q;
    count_d    = count_q;
    dz_d       = dz_q;
    if (accept) begin
      dividend_d = X;
      divisor_d  = Y;
      quot_d     = '0;
      partRem_d  = '0;
      count_d    = CntW'(widthX);
      dz_d       = (Y == '0);
`ifdef DIVUNS_FAST_DZ_EN
      if (Y == '0) begin
        quot_d    = '1;
        partRem_d = {1'b0, X[widthY-1:0]};
        count_d   = '0;
      end
`endif
    end else if (state_q == BUSY) begin
      dividend_d = dividend_q << 1;
      quot_d     = (quot_q << 1) | widthX'(fitBit);
      if (fitBit) begin
        partRem_d = (widthY+1)'(shifted - yExt);
      end else begin
        partRem_d = shifted[widthY:0];
      end
      count_d    = count_q - CntW'(1);
    end
  end

  // State and datapath registers.
  // Reset is synchronous and overrides both handshakes. Reset discards any
  // division in flight and any pending result, so neither is ever presented.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      partRem_q  <= '0;
      count_q    <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      partRem_q  <= partRem_d;
      count_q    <= count_d;
      dz_q       <= dz_d;
    end
  end

  // The result outputs come straight from the registers.
  // The partial remainder's extra top bit is only working headroom.
  assign Q    = quot_q;
  assign R    = partRem_q[widthY-1:0];
  assign dz_o = dz_q;

endmodule

// File: tb/tb_div_uns_seq.sv
// ---------------------------------------------------------------------------
// tb_div_uns_seq
//
// Self-checking bench for div_uns_seq at widthX = widthY = 16.
// - Directed cases: reset state, known quotients and remainders, divide by
//   zero, result hold under backpressure, and reset during a busy division.
// - Random cases: a back-to-back random run checked against a plain
//   floor/mod reference, including the spacing between results.
// The bench follows DIVUNS_FAST_DZ_EN for the expected divide-by-zero
// latency.
// ---------------------------------------------------------------------------
module tb_div_uns_seq;

  localparam int WX = 16;
  localparam int WY = 16;
`ifdef DIVUNS_FAST_DZ_EN
  localparam int DzLat = 1;
`else
  localparam int DzLat = 17;
`endif
  localparam int OpLat = WX + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [WX-1:0] X = '0;
  logic [WY-1:0] Y = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [WX-1:0] Q;
  logic [WY-1:0] R;
  logic          dz_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;

  div_uns_seq #(.widthX(WX), .widthY(WY)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .X(X),
    .Y(Y),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .Q(Q),
    .R(R),
    .dz_o(dz_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  // Free-running clock, plus a cycle counter that timestamps results.
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycleCnt <= cycleCnt + 1;

  // Safety net, so that a wedged design can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: plain integer floor division, with the divide-by-zero
  // convention Q = all ones, R = low dividend bits.
  function automatic void refDiv(input logic [WX-1:0] x, input logic [WY-1:0] y,
                                 output logic [WX-1:0] q, output logic [WY-1:0] r,
                                 output logic dz);
    if (y == 0) begin
      q  = '1;
      r  = x[WY-1:0];
      dz = 1'b1;
    end else begin
      q  = x / y;
      r  = x % y;
      dz = 1'b0;
    end
  endfunction

  // Offer one pair once the divider is ready. Right after acceptance, the
  // input bus is scrambled to show that the captured operands are used.
  task automatic applyStimulus(input logic [WX-1:0] x, input logic [WY-1:0] y);
    int n = 0;
    while (in_ready_o !== 1'b1 && n < 100) begin
      nextCycle();
      n++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready_o), 32'd1);
    X = x;
    Y = y;
    in_valid_i = 1'b1;
    nextCycle();
    in_valid_i = 1'b0;
    X = WX'($urandom);
    Y = WY'($urandom);
  endtask

  // Count cycles from acceptance until out_valid_o rises.
  // lat = 1 means the result appears in the cycle right after acceptance.
  task automatic waitResult(output int lat, output int atCycle);
    lat = 1;
    while (out_valid_o !== 1'b1 && lat < 100) begin
      nextCycle();
      lat++;
    end
    atCycle = cycleCnt;
  endtask

  // Run one complete operation and compare it with the reference model.
  task automatic runOp(input string tag, input logic [WX-1:0] x, input logic [WY-1:0] y,
                       input int expLat, output int atCycle);
    logic [WX-1:0] eq;
    logic [WY-1:0] er;
    logic          edz;
    int            lat;
    refDiv(x, y, eq, er, edz);
    applyStimulus(x, y);
    waitResult(lat, atCycle);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_Q"}, 32'(Q), 32'(eq));
    checkOutput({tag, "_R"}, 32'(R), 32'(er));
    checkOutput({tag, "_dz"}, 32'(dz_o), 32'(edz));
  endtask

  initial begin
    int at;
    int lastAt;
    int seen;
    logic [WX-1:0] rx;
    logic [WY-1:0] ry;

    // Reset state: IDLE, with all result registers cleared.
    rst_i = 1'b1;
    nextCycle();
    nextCycle();
    rst_i = 1'b0;
    checkOutput("reset_in_ready", 32'(in_ready_o), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("reset_Q", 32'(Q), 32'd0);
    checkOutput("reset_R", 32'(R), 32'd0);
    checkOutput("reset_dz", 32'(dz_o), 32'd0);

    // 1000/7 with the consumer stalled. The result must hold for 5 cycles.
    out_ready_i = 1'b0;
    runOp("div_1000_7", 16'd1000, 16'd7, OpLat, at);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput("hold_Q", 32'(Q), 32'd142);
      checkOutput("hold_R", 32'(R), 32'd6);
      checkOutput("hold_dz", 32'(dz_o), 32'd0);
      checkOutput("hold_out_valid", 32'(out_valid_o), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready_o), 32'd0);
    end
    out_ready_i = 1'b1;
    nextCycle();
    checkOutput("release_in_ready", 32'(in_ready_o), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid_o), 32'd0);

    // Boundary cases: Y = 1, X < Y, and divide by zero.
    runOp("div_ffff_1", 16'hFFFF, 16'd1, OpLat, at);
    runOp("div_5_9", 16'd5, 16'd9, OpLat, at);
    runOp("div_1234_0", 16'h1234, 16'd0, DzLat, at);
    runOp("div_0_0", 16'h0000, 16'd0, DzLat, at);

    // Reset in the 8th BUSY cycle. in_valid_i is held high to show that
    // reset wins over it.
    applyStimulus(16'hABCD, 16'd3);
    repeat (7) nextCycle();
    rst_i = 1'b1;
    in_valid_i = 1'b1;
    nextCycle();
    rst_i = 1'b0;
    in_valid_i = 1'b0;
    checkOutput("abort_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready_o), 32'd1);
    checkOutput("abort_Q", 32'(Q), 32'd0);
    checkOutput("abort_R", 32'(R), 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      if (out_valid_o === 1'b1) seen++;
    end
    checkOutput("abort_no_result", 32'(seen), 32'd0);
    runOp("div_100_10", 16'd100, 16'd10, OpLat, at);

    // Random back-to-back run with the consumer always ready. Results must
    // be exactly widthX+2 cycles apart.
    lastAt = 0;
    for (int i = 0; i < 24; i++) begin
      rx = WX'($urandom);
      if (i % 3 == 0) ry = WY'($urandom);
      else ry = WY'($urandom_range(1, 300));
      if (ry == 0) ry = 1;
      runOp("rand", rx, ry, OpLat, at);
      if (i > 0) checkOutput("rand_spacing", 32'(at - lastAt), 32'(WX + 2));
      lastAt = at;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
